// File: rtl/delay_commutator_pkg.sv
// ----------------------------------------------------------------------------
// delay_commutator_pkg
//
// Shared sizing helpers for the delay-commutator slice. The datapath carries
// opaque samples, so no shared data types are needed. Only the counter widths
// derived from DELAY live here, so the top and the delay lines size them the
// same way.
// ----------------------------------------------------------------------------
package delay_commutator_pkg;

    // Width of a counter that runs over 0 .. 2*delay-1 (never below 1 bit).
    function automatic int unsigned phase_width(input int unsigned delay);
        int unsigned w;
        w = $clog2(2 * delay);
        return (w < 1) ? 1 : w;
    endfunction

    // Width of a fill counter that saturates at delay (never below 1 bit).
    function automatic int unsigned fill_width(input int unsigned delay);
        int unsigned w;
        w = $clog2(delay + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/delay_commutator_delay_buffer.sv
// ----------------------------------------------------------------------------
// delay_buffer
//
// Enable-gated DELAY-deep shift register with a saturating fill counter.
// The output is the oldest tap, read combinationally. While the current
// accepted sample is presented at in, out shows the sample accepted DELAY
// acceptances earlier (zeros until the line has filled).
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high; clears taps and fill counter
//   enable     shift in / advance only when high
//   in         sample entering the line
//   out        sample leaving the line (in delayed by DELAY acceptances)
//   out_valid  high once DELAY samples have been accepted since reset
// ----------------------------------------------------------------------------
module delay_buffer
    import delay_commutator_pkg::*;
#(
    parameter int unsigned DELAY      = 4,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] in,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  out_valid
);

    localparam int unsigned   CW   = fill_width(DELAY);
    localparam logic [CW-1:0] FULL = CW'(DELAY);

    logic [DATA_WIDTH-1:0] taps [DELAY];
    logic [CW-1:0]         delay_counter;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DELAY; i++) begin
                taps[i] <= '0;
            end
            delay_counter <= '0;
        end else if (enable) begin
            taps[0] <= in;
            for (int unsigned i = 1; i < DELAY; i++) begin
                taps[i] <= taps[i-1];
            end
            if (delay_counter != FULL) begin
                delay_counter <= delay_counter + CW'(1);
            end
        end
    end

    assign out       = taps[DELAY-1];
    assign out_valid = (delay_counter == FULL);

endmodule

// File: rtl/delay_commutator.sv
// ----------------------------------------------------------------------------
// delay_commutator
//
// Two-lane delay-commutator stage of a pipelined MDC FFT. Lane 1 is delayed by
// DELAY samples. The lanes are swapped on every second DELAY-sample block, and
// the resulting lane 0 is then delayed by DELAY samples. The net effect is that
// the second half of each lane-0 block is exchanged with the first half of the
// matching lane-1 block. The outputs are registered and appear DELAY accepted
// samples after the corresponding input.
//
// Ports:
//   clk                   system clock, rising edge
//   reset                 synchronous, active-high; clears all state
//   enable                sample valid / advance; all state holds when low
//   x0, x1                lane-0 / lane-1 input samples
//   y0, y1                lane-0 / lane-1 output samples (registered)
//   commutator_out_valid  high once DELAY samples have been accepted since
//                         reset (registered, sticky until reset)
// ----------------------------------------------------------------------------
module delay_commutator
    import delay_commutator_pkg::*;
#(
    parameter int unsigned DELAY      = 4,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] x0,
    input  logic [DATA_WIDTH-1:0] x1,
    output logic [DATA_WIDTH-1:0] y0,
    output logic [DATA_WIDTH-1:0] y1,
    output logic                  commutator_out_valid
);

    localparam int unsigned   PW         = phase_width(DELAY);
    localparam logic [PW-1:0] PHASE_LAST = PW'(2 * DELAY - 1);
    localparam logic [PW-1:0] SWAP_START = PW'(DELAY);

    logic [PW-1:0]         phase;
    logic                  swap;
    logic [DATA_WIDTH-1:0] x1d;
    logic [DATA_WIDTH-1:0] s0;
    logic [DATA_WIDTH-1:0] s1;
    logic [DATA_WIDTH-1:0] d0;
    logic                  x1_filled;
    logic                  y0_filled;

    // Lane 1 is delayed before the switch.
    delay_buffer #(
        .DELAY      (DELAY),
        .DATA_WIDTH (DATA_WIDTH)
    ) delay_x1 (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .in        (x1),
        .out       (x1d),
        .out_valid (x1_filled)
    );

    // The phase is the accepted-sample index mod 2*DELAY, and the second half
    // of each period swaps the lanes.
    always_comb begin
        swap = (phase >= SWAP_START);
        if (swap) begin
            s0 = x1d;
            s1 = x0;
        end else begin
            s0 = x0;
            s1 = x1d;
        end
    end

    // Lane 0 is delayed after the switch.
    delay_buffer #(
        .DELAY      (DELAY),
        .DATA_WIDTH (DATA_WIDTH)
    ) delay_y0 (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .in        (s0),
        .out       (d0),
        .out_valid (y0_filled)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            phase                <= '0;
            y0                   <= '0;
            y1                   <= '0;
            commutator_out_valid <= 1'b0;
        end else if (enable) begin
            phase <= (phase == PHASE_LAST) ? '0 : phase + PW'(1);
            y0    <= d0;
            y1    <= s1;
            // Both lines fill in lockstep, so either counter marks n >= DELAY.
            // Combining them keeps both counters meaningful.
            commutator_out_valid <= x1_filled & y0_filled;
        end
    end

endmodule

// File: tb/tb_delay_commutator.sv
module tb_delay_commutator;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [DW-1:0] x0;
    logic [DW-1:0] x1;

    logic [DW-1:0] y0_a, y1_a, y0_b, y1_b;
    logic          v_a, v_b;

    int unsigned tests_run    = 0;
    int unsigned tests_failed = 0;

    // Accepted-sample history since the last reset (index = n).
    logic [DW-1:0] h0[$];
    logic [DW-1:0] h1[$];

    // Expected outputs for the DELAY=4 (a) and DELAY=1 (b) instances.
    logic [DW-1:0] e0_a, e1_a, e0_b, e1_b;
    logic          ev_a, ev_b;

    always #5 clk = ~clk;

    delay_commutator #(.DELAY(4), .DATA_WIDTH(DW)) dut_a (
        .clk                  (clk),
        .reset                (reset),
        .enable               (enable),
        .x0                   (x0),
        .x1                   (x1),
        .y0                   (y0_a),
        .y1                   (y1_a),
        .commutator_out_valid (v_a)
    );

    delay_commutator #(.DELAY(1), .DATA_WIDTH(DW)) dut_b (
        .clk                  (clk),
        .reset                (reset),
        .enable               (enable),
        .x0                   (x0),
        .x1                   (x1),
        .y0                   (y0_b),
        .y1                   (y1_b),
        .commutator_out_valid (v_b)
    );

    task automatic check_value(input string tag, input logic [DW-1:0] got,
                               input logic [DW-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: the delayed lane-1 value seen at sample k, and the
    // post-switch lanes s0/s1 at sample k. Unfilled history reads as zero.
    function automatic logic [DW-1:0] x1d_at(input int d, input int k);
        if (k - d < 0) return '0;
        return h1[k-d];
    endfunction

    function automatic logic [DW-1:0] s0_at(input int d, input int k);
        if (k < 0) return '0;
        if ((k % (2 * d)) >= d) return x1d_at(d, k);
        return h0[k];
    endfunction

    function automatic logic [DW-1:0] s1_at(input int d, input int k);
        if ((k % (2 * d)) >= d) return h0[k];
        return x1d_at(d, k);
    endfunction

    // Apply one cycle of stimulus, update the model and compare all outputs.
    task automatic step(input logic en, input logic rst,
                        input logic [DW-1:0] a, input logic [DW-1:0] b);
        int n;
        enable = en;
        reset  = rst;
        x0     = a;
        x1     = b;
        @(posedge clk);
        #1;
        if (rst) begin
            h0.delete();
            h1.delete();
            e0_a = '0; e1_a = '0; ev_a = 1'b0;
            e0_b = '0; e1_b = '0; ev_b = 1'b0;
        end else if (en) begin
            h0.push_back(a);
            h1.push_back(b);
            n    = h0.size() - 1;
            e0_a = s0_at(4, n - 4);
            e1_a = s1_at(4, n);
            ev_a = (n >= 4);
            e0_b = s0_at(1, n - 1);
            e1_b = s1_at(1, n);
            ev_b = (n >= 1);
        end
        check_value("y0_d4",    y0_a,      e0_a);
        check_value("y1_d4",    y1_a,      e1_a);
        check_value("valid_d4", DW'(v_a),  DW'(ev_a));
        check_value("y0_d1",    y0_b,      e0_b);
        check_value("y1_d1",    y1_b,      e1_b);
        check_value("valid_d1", DW'(v_b),  DW'(ev_b));
    endtask

    int unsigned tbl_y0_d4 [8] = '{0, 1, 2, 3, 8, 9, 10, 11};
    int unsigned tbl_y1_d4 [8] = '{4, 5, 6, 7, 12, 13, 14, 15};
    int unsigned tbl_y0_d1 [4] = '{0, 10, 2, 12};
    int unsigned tbl_y1_d1 [4] = '{1, 11, 3, 13};

    initial begin
        enable = 1'b0;
        reset  = 1'b0;
        x0     = '0;
        x1     = '0;

        // Reset held for two cycles.
        step(1'b1, 1'b1, 16'd99, 16'd77);
        step(1'b1, 1'b1, 16'd55, 16'd33);

        // Basic reorder with D=4 against the known net mapping as well.
        for (int n = 0; n < 18; n++) begin
            if (n < 8) step(1'b1, 1'b0, DW'(n), DW'(n + 8));
            else       step(1'b1, 1'b0, '0, '0);
            if (n >= 4 && n <= 11) begin
                check_value("map_y0_d4", y0_a, DW'(tbl_y0_d4[n-4]));
                check_value("map_y1_d4", y1_a, DW'(tbl_y1_d4[n-4]));
            end
            if (n == 3) check_value("no_valid_n3", DW'(v_a), '0);
            if (n == 4) check_value("valid_n4",    DW'(v_a), 16'd1);
        end

        // Same stream with an enable gap of 3 cycles after n=5.
        step(1'b0, 1'b1, '0, '0);
        for (int n = 0; n < 18; n++) begin
            if (n < 8) step(1'b1, 1'b0, DW'(n), DW'(n + 8));
            else       step(1'b1, 1'b0, '0, '0);
            if (n == 5) begin
                for (int g = 0; g < 3; g++) begin
                    step(1'b0, 1'b0, 16'hdead, 16'hbeef);
                    check_value("gap_hold_y0", y0_a, 16'd1);
                    check_value("gap_hold_y1", y1_a, 16'd5);
                end
            end
        end

        // Phase wrap over four 2D blocks.
        step(1'b1, 1'b1, '0, '0);
        for (int n = 0; n < 36; n++) begin
            if (n < 32) step(1'b1, 1'b0, DW'(n), DW'(n + 1000));
            else        step(1'b1, 1'b0, '0, '0);
        end

        // Reset mid-stream at n=6, then restart.
        step(1'b1, 1'b1, '0, '0);
        for (int n = 0; n < 6; n++) step(1'b1, 1'b0, DW'(n + 500), DW'(n + 600));
        step(1'b1, 1'b1, 16'd123, 16'd456);
        check_value("mid_reset_valid", DW'(v_a), '0);
        for (int n = 0; n < 12; n++) begin
            step(1'b1, 1'b0, DW'(n + 20), DW'(n + 40));
            if (n == 3) check_value("refill_n3", DW'(v_a), '0);
            if (n == 4) check_value("refill_n4", DW'(v_a), 16'd1);
        end

        // DELAY=1 corner against the known mapping.
        step(1'b1, 1'b1, '0, '0);
        for (int n = 0; n < 6; n++) begin
            if (n < 4) step(1'b1, 1'b0, DW'(n), DW'(n + 10));
            else       step(1'b1, 1'b0, '0, '0);
            if (n == 0) check_value("d1_valid_n0", DW'(v_b), '0);
            if (n >= 1 && n <= 4) begin
                check_value("map_y0_d1", y0_b, DW'(tbl_y0_d1[n-1]));
                check_value("map_y1_d1", y1_b, DW'(tbl_y1_d1[n-1]));
                check_value("d1_valid",  DW'(v_b), 16'd1);
            end
        end

        // Randomized traffic with enable gaps and occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0),
                 DW'($urandom), DW'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/delay_commutator.md
Name: delay_commutator

Overview:
Two-lane delay-commutator stage of the pipelined MDC FFT datapath. It delays lane 1 by DELAY samples and swaps lanes on alternate DELAY-sample blocks. It then delays lane 0 by DELAY samples, so the second half of each lane-0 block is exchanged with the first half of the matching lane-1 block. It sits between butterfly stages and re-pairs samples for the next stage.

Parameters:
DELAY, 4, commutator block length D in samples; must be >= 1.
DATA_WIDTH, 16, width of each lane sample in bits (opaque data, no arithmetic).

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  sample-valid/advance; state updates only when high
x0  in  DATA_WIDTH  lane-0 input sample
x1  in  DATA_WIDTH  lane-1 input sample
y0  out  DATA_WIDTH  lane-0 output sample (registered)
y1  out  DATA_WIDTH  lane-1 output sample (registered)
commutator_out_valid  out  1  y0/y1 carry meaningful data (registered)

Behaviour:
- One clock domain (clk). reset is synchronous and active-high. On reset, all delay registers, the phase counter, fill counters, y0, y1 and commutator_out_valid are 0.
- Number accepted samples n = 0,1,2,... counting only edges where enable=1 and reset=0. While enable=0, every register holds and outputs hold.
- x1d[n] = x1[n-D]: lane 1 passes through a D-deep shift register.
- phase = n mod 2D, held in a counter that wraps 2D-1 -> 0. swap = (phase >= D).
- Switch: if swap, s0 = x1d, s1 = x0; else s0 = x0, s1 = x1d.
- s0 passes through a second D-deep shift register: d0[n] = s0[n-D].
- The output register loads y0 <= d0[n], y1 <= s1[n], commutator_out_valid <= (n >= D) on the accepted edge of sample n.
- Net mapping with D=4 for inputs x0 = 0..7 and x1 = 8..15: output y0 = 0,1,2,3,8,9,10,11 and y1 = 4,5,6,7,12,13,14,15. These outputs appear on accepted samples n = 4..11.
- Valid handling: each delay line keeps a fill counter that saturates at D. commutator_out_valid is 1 once D samples have been accepted since reset. It then stays 1 until reset; it is not dropped by enable=0. Output values produced before fill (n < D) are don't-care for consumers but deterministic, computed from zeros in unfilled registers.
- Reset mid-stream clears everything. Phase restarts at 0 and valid drops the cycle after the reset edge.
- Continuous enable=1 with no gaps gives a throughput of one sample pair per cycle.
- Latency from a sample's acceptance to its appearance on the output register is D accepted samples, sampled on the same edge as input n+D.

Decomposition:
- No shared package types are needed. DATA_WIDTH and DELAY stay module parameters. Phase counter width is $clog2(2*DELAY), with a minimum of 1.
- Sub-module delay_buffer (params DELAY, DATA_WIDTH; ports clk, reset, enable, in, out, out_valid). It is an enable-gated D-deep shift register with a saturating delay_counter driving out_valid.
- delay_commutator instantiates delay_buffer twice: delay_x1 on lane 1 before the switch, and delay_y0 on lane 0 after the switch. It also holds the phase counter, switch muxes and output register.

Test Plan:
- Reset with D=4: hold reset 2 cycles -> y0=0, y1=0, commutator_out_valid=0 on every edge.
- Basic reorder, D=4: enable=1, x0=n, x1=n+8 for n=0..7, then zeros for 10 samples -> valid rises at n=4. (y0,y1) = (0,4),(1,5),(2,6),(3,7),(8,12),(9,13),(10,14),(11,15) for n=4..11, then (0,0).
- Enable gaps: same stream as the basic reorder with enable=0 for 3 cycles after n=5 -> outputs and valid hold during the gap; the sequence resumes with no loss or duplication.
- Phase wrap: stream 4 blocks (x0=n, x1=n+1000 for n=0..31, D=4) -> swap is active exactly when n mod 8 is in 4..7 across every wrap. The output obeys the lane mapping per 2D block.
- Reset mid-stream: assert reset at n=6 for one cycle, then restart at n=0 -> valid=0 immediately after reset and re-asserts only after 4 new accepted samples. Data is uncontaminated by pre-reset samples.
- DELAY=1 corner: x0=0,1,2,3 and x1=10,11,12,13 -> y0 = 0,10,2,12 and y1 = 1,11,3,13 on n=1..4; valid from n=1.
